// File: rtl/digit_overlay_pkg.sv
`default_nettype none
// ============================================================================
// Module      : digit_overlay_pkg
// Description : Shared types, sizes and blank-mask helper for the digit overlay.
// Revision    : 1.0 - initial release
// ============================================================================
package digit_overlay_pkg;

    localparam int GLYPH_W = 16;
    localparam int GLYPH_H = 16;
    localparam int N_FRE   = 6;
    localparam int N_VOPP  = 3;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        FIELD_FRE  = 1'b0,
        FIELD_VOPP = 1'b1
    } field_e;

    // Bit i of the result belongs to nibble i (bit 0 = units). Only the
    // lowest n nibbles are examined; higher result bits stay 0.
    function automatic logic [N_FRE-1:0] blank_mask(
        input logic [4*N_FRE-1:0] nibs,
        input int                 n,
        input logic               lz
    );
        logic [N_FRE-1:0] mask;
        logic             zero_above;
        bcd_t             nib;
        mask       = '0;
        zero_above = 1'b1;
        for (int i = N_FRE - 1; i >= 0; i--) begin
            if (i < n) begin
                nib        = nibs[i*4 +: 4];
                mask[i]    = (nib > 4'd9) || (lz && zero_above && (nib == 4'd0) && (i != 0));
                zero_above = zero_above && (nib == 4'd0);
            end
        end
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/overlay_cell_decode.sv
`default_nettype none
// ============================================================================
// Module      : overlay_cell_decode
// Description : Maps a pixel position to the digit cell it hits, if any.
// Revision    : 1.0 - initial release
// ============================================================================
module overlay_cell_decode
    import digit_overlay_pkg::*;
#(
    parameter int FRE_X0  = 200,
    parameter int FRE_Y0  = 100,
    parameter int VOPP_X0 = 200,
    parameter int VOPP_Y0 = 140,
    parameter int PITCH   = 20
) (
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       hit,
    output field_e     field,
    output logic [2:0] k,
    output logic [3:0] row,
    output logic [3:0] col
);

    localparam logic [10:0] c_fre_y0  = 11'(FRE_Y0);
    localparam logic [10:0] c_vopp_y0 = 11'(VOPP_Y0);
    localparam logic [10:0] c_h_last  = 11'(GLYPH_H - 1);
    localparam logic [10:0] c_w_last  = 11'(GLYPH_W - 1);

    logic [10:0]      w_x;
    logic [10:0]      w_y;
    logic             w_fre_row_in;
    logic             w_vopp_row_in;
    logic [3:0]       w_fre_row;
    logic [3:0]       w_vopp_row;
    logic [N_FRE-1:0] w_fre_col_in;
    logic [N_VOPP-1:0] w_vopp_col_in;
    logic [3:0]       w_fre_col  [N_FRE];
    logic [3:0]       w_vopp_col [N_VOPP];

    assign w_x = {1'b0, pix_x};
    assign w_y = {1'b0, pix_y};

    assign w_fre_row_in  = (w_y >= c_fre_y0)  && (w_y <= c_fre_y0 + c_h_last);
    assign w_vopp_row_in = (w_y >= c_vopp_y0) && (w_y <= c_vopp_y0 + c_h_last);
    assign w_fre_row     = pix_y[3:0] - c_fre_y0[3:0];
    assign w_vopp_row    = pix_y[3:0] - c_vopp_y0[3:0];

    // Cell origins are elaboration-time constants, so each cell costs only
    // two comparators and a 4-bit subtract.
    generate
        for (genvar i = 0; i < N_FRE; i++) begin : g_fre_cell
            localparam logic [10:0] c_x0 = 11'(FRE_X0 + PITCH * i);
            assign w_fre_col_in[i] = (w_x >= c_x0) && (w_x <= c_x0 + c_w_last);
            assign w_fre_col[i]    = pix_x[3:0] - c_x0[3:0];
        end
        for (genvar i = 0; i < N_VOPP; i++) begin : g_vopp_cell
            localparam logic [10:0] c_x0 = 11'(VOPP_X0 + PITCH * i);
            assign w_vopp_col_in[i] = (w_x >= c_x0) && (w_x <= c_x0 + c_w_last);
            assign w_vopp_col[i]    = pix_x[3:0] - c_x0[3:0];
        end
    endgenerate

    // Vpp is resolved first so an overlapping frequency cell overrides it.
    always_comb begin
        hit   = 1'b0;
        field = FIELD_FRE;
        k     = 3'd0;
        row   = 4'd0;
        col   = 4'd0;
        if (w_vopp_row_in) begin
            for (int i = 0; i < N_VOPP; i++) begin
                if (w_vopp_col_in[i]) begin
                    hit   = 1'b1;
                    field = FIELD_VOPP;
                    k     = 3'(i);
                    row   = w_vopp_row;
                    col   = w_vopp_col[i];
                end
            end
        end
        if (w_fre_row_in) begin
            for (int i = 0; i < N_FRE; i++) begin
                if (w_fre_col_in[i]) begin
                    hit   = 1'b1;
                    field = FIELD_FRE;
                    k     = 3'(i);
                    row   = w_fre_row;
                    col   = w_fre_col[i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/digit_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : digit_overlay_ctrl
// Description : Frame-synchronous BCD readout overlay driving a shared glyph ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_overlay_ctrl
    import digit_overlay_pkg::*;
#(
    parameter int FRE_X0    = 200,
    parameter int FRE_Y0    = 100,
    parameter int VOPP_X0   = 200,
    parameter int VOPP_Y0   = 140,
    parameter int PITCH     = 20,
    parameter int VS_ACTIVE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [23:0] fre_bcd,
    input  logic [11:0] vopp_bcd,
    input  logic        lz_en,
    output logic [3:0]  glyph_num,
    output logic [3:0]  glyph_addr,
    input  logic [15:0] glyph_row,
    output logic        pix_on,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out
);

    localparam logic c_vs_act = 1'(VS_ACTIVE);

    logic              r_upd_ready;
    logic              r_pending_flag;
    logic [23:0]       r_pend_fre;
    logic [11:0]       r_pend_vopp;
    logic              r_pend_lz;
    logic [23:0]       r_disp_fre;
    logic [11:0]       r_disp_vopp;
    logic [N_FRE-1:0]  r_blank_fre;
    logic [N_VOPP-1:0] r_blank_vopp;
    logic              r_vs_prev;

    logic [3:0]        r_glyph_num;
    logic [3:0]        r_glyph_addr;
    logic [3:0]        r_col;
    logic              r_hit_q;
    logic              r_pix_on;
    logic [2:0]        r_sync_d1;
    logic [2:0]        r_sync_d2;

    logic              w_accept;
    logic              w_frame_edge;
    logic              w_apply;
    logic              w_pending_nxt;
    logic [N_FRE-1:0]  w_mask_fre;
    logic [N_FRE-1:0]  w_mask_vopp;
    logic [N_FRE-N_VOPP-1:0] w_unused_mask_hi;

    logic              w_hit_raw;
    logic              w_hit;
    field_e            w_field;
    logic [2:0]        w_k;
    logic [3:0]        w_row;
    logic [3:0]        w_col;
    bcd_t              w_nib;
    logic              w_blank;

    // ------------------------------------------------------------------
    // Update handshake and frame-start application
    // ------------------------------------------------------------------
    assign w_accept     = upd_valid & r_upd_ready;
    assign w_frame_edge = (vs_in == c_vs_act) && (r_vs_prev != c_vs_act);
    assign w_apply      = w_frame_edge & r_pending_flag;

    always_comb begin
        w_pending_nxt = r_pending_flag;
        if (w_apply) begin
            w_pending_nxt = 1'b0;
        end
        if (w_accept) begin
            w_pending_nxt = 1'b1;
        end
    end

    assign w_mask_fre       = blank_mask(r_pend_fre, N_FRE, r_pend_lz);
    assign w_mask_vopp      = blank_mask({12'h000, r_pend_vopp}, N_VOPP, r_pend_lz);
    assign w_unused_mask_hi = w_mask_vopp[N_FRE-1:N_VOPP];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_upd_ready    <= 1'b0;
            r_pending_flag <= 1'b0;
            r_pend_fre     <= '0;
            r_pend_vopp    <= '0;
            r_pend_lz      <= 1'b0;
            r_disp_fre     <= '0;
            r_disp_vopp    <= '0;
            r_blank_fre    <= '0;
            r_blank_vopp   <= '0;
            r_vs_prev      <= c_vs_act;
        end else begin
            r_vs_prev      <= vs_in;
            r_pending_flag <= w_pending_nxt;
            r_upd_ready    <= !w_pending_nxt;
            // The display copy reads the old pending values, so a same-cycle
            // accept is held over to the next frame.
            if (w_apply) begin
                r_disp_fre   <= r_pend_fre;
                r_disp_vopp  <= r_pend_vopp;
                r_blank_fre  <= w_mask_fre;
                r_blank_vopp <= w_mask_vopp[N_VOPP-1:0];
            end
            if (w_accept) begin
                r_pend_fre  <= fre_bcd;
                r_pend_vopp <= vopp_bcd;
                r_pend_lz   <= lz_en;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: cell decode and ROM address
    // ------------------------------------------------------------------
    overlay_cell_decode #(
        .FRE_X0  (FRE_X0),
        .FRE_Y0  (FRE_Y0),
        .VOPP_X0 (VOPP_X0),
        .VOPP_Y0 (VOPP_Y0),
        .PITCH   (PITCH)
    ) u_cell_decode (
        .pix_x (pix_x),
        .pix_y (pix_y),
        .hit   (w_hit_raw),
        .field (w_field),
        .k     (w_k),
        .row   (w_row),
        .col   (w_col)
    );

    assign w_hit = de_in & w_hit_raw;

    always_comb begin
        w_nib   = '0;
        w_blank = 1'b0;
        if (w_field == FIELD_FRE) begin
            for (int i = 0; i < N_FRE; i++) begin
                if (w_k == 3'(i)) begin
                    w_nib   = r_disp_fre[(N_FRE-1-i)*4 +: 4];
                    w_blank = r_blank_fre[N_FRE-1-i];
                end
            end
        end else begin
            for (int i = 0; i < N_VOPP; i++) begin
                if (w_k == 3'(i)) begin
                    w_nib   = r_disp_vopp[(N_VOPP-1-i)*4 +: 4];
                    w_blank = r_blank_vopp[N_VOPP-1-i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_glyph_num  <= '0;
            r_glyph_addr <= '0;
            r_col        <= '0;
            r_hit_q      <= 1'b0;
        end else begin
            r_hit_q <= w_hit & !w_blank;
            if (w_hit) begin
                r_glyph_num  <= (w_nib > 4'd9) ? 4'd0 : w_nib;
                r_glyph_addr <= w_row;
                r_col        <= w_col;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: ROM bit select and sync alignment
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix_on  <= 1'b0;
            r_sync_d1 <= '0;
            r_sync_d2 <= '0;
        end else begin
            r_pix_on  <= r_hit_q & glyph_row[4'd15 - r_col];
            r_sync_d1 <= {de_in, hs_in, vs_in};
            r_sync_d2 <= r_sync_d1;
        end
    end

    assign upd_ready  = r_upd_ready;
    assign glyph_num  = r_glyph_num;
    assign glyph_addr = r_glyph_addr;
    assign pix_on     = r_pix_on;
    assign de_out     = r_sync_d2[2];
    assign hs_out     = r_sync_d2[1];
    assign vs_out     = r_sync_d2[0];

endmodule
`default_nettype wire

// File: tb/tb_digit_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_overlay_ctrl
// Description : Directed, table-driven bench for digit_overlay_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_overlay_ctrl;

    logic        clk;
    logic        rst_n;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        de_in;
    logic        hs_in;
    logic        vs_in;
    logic        upd_valid;
    logic        upd_ready;
    logic [23:0] fre_bcd;
    logic [11:0] vopp_bcd;
    logic        lz_en;
    logic [3:0]  glyph_num;
    logic [3:0]  glyph_addr;
    logic [15:0] glyph_row;
    logic        pix_on;
    logic        de_out;
    logic        hs_out;
    logic        vs_out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         phase;
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       chk_g;
        logic [3:0] num;
        logic [3:0] addr;
        logic [3:0] col;
        logic       vis;
    } vec_t;

    vec_t vecs[$];

    // Bench glyph ROM: "1" row is 0x0180, other digits a row/digit-dependent pattern.
    function automatic logic [15:0] rom(input logic [3:0] d, input logic [3:0] r);
        if (d == 4'd1) return 16'h0180;
        return {d, r, ~d, ~r};
    endfunction

    assign glyph_row = rom(glyph_num, glyph_addr);

    digit_overlay_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .de_in      (de_in),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .fre_bcd    (fre_bcd),
        .vopp_bcd   (vopp_bcd),
        .lz_en      (lz_en),
        .glyph_num  (glyph_num),
        .glyph_addr (glyph_addr),
        .glyph_row  (glyph_row),
        .pix_on     (pix_on),
        .de_out     (de_out),
        .hs_out     (hs_out),
        .vs_out     (vs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input int p, input int x, input int y, input logic de, input logic cg,
                       input int num, input int addr, input int col, input logic vis);
        vec_t v;
        v.phase = p;       v.x = 10'(x);       v.y = 10'(y);
        v.de = de;         v.chk_g = cg;       v.num = 4'(num);
        v.addr = 4'(addr); v.col = 4'(col);    v.vis = vis;
        vecs.push_back(v);
    endtask

    task automatic probe(input vec_t v, input int idx);
        logic [15:0] rr;
        logic        exp_on;
        rr     = rom(v.num, v.addr);
        exp_on = v.vis & rr[4'd15 - v.col];
        @(negedge clk);
        pix_x = v.x; pix_y = v.y; de_in = v.de;
        @(negedge clk);
        if (v.chk_g) begin
            chk($sformatf("vec%0d_glyph_num", idx), 24'(glyph_num), 24'(v.num));
            chk($sformatf("vec%0d_glyph_addr", idx), 24'(glyph_addr), 24'(v.addr));
        end
        de_in = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d_pix_on", idx), 24'(pix_on), 24'(exp_on));
    endtask

    task automatic run_phase(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) probe(vecs[i], i);
        end
    endtask

    task automatic accept(input logic [23:0] f, input logic [11:0] v, input logic lz);
        @(negedge clk);
        fre_bcd = f; vopp_bcd = v; lz_en = lz; upd_valid = 1'b1;
        chk("ready_pre_accept", 24'(upd_ready), 24'd1);
        @(negedge clk);
        upd_valid = 1'b0;
        chk("ready_post_accept", 24'(upd_ready), 24'd0);
    endtask

    task automatic frame_edge(input logic offer, input logic [23:0] f, input logic [11:0] v,
                              input logic lz, input logic rdy_at, input logic rdy_after);
        @(negedge clk);
        vs_in = 1'b0;
        if (offer) begin
            fre_bcd = f; vopp_bcd = v; lz_en = lz; upd_valid = 1'b1;
        end
        chk("ready_at_edge", 24'(upd_ready), 24'(rdy_at));
        @(negedge clk);
        upd_valid = 1'b0;
        chk("ready_after_edge", 24'(upd_ready), 24'(rdy_after));
        repeat (2) @(negedge clk);
        vs_in = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; pix_x = '0; pix_y = '0; de_in = 1'b0; hs_in = 1'b0; vs_in = 1'b1;
        upd_valid = 1'b0; fre_bcd = '0; vopp_bcd = '0; lz_en = 1'b0;

        // phase, x, y, de, check glyph, num, addr, col, visible
        add(0, 203, 100, 1, 1, 0, 0,  3, 1);
        add(0, 212, 100, 1, 1, 0, 0, 12, 1);
        add(1, 200, 100, 1, 1, 0, 0,  0, 0);
        add(1, 223, 105, 1, 1, 1, 5,  3, 1);
        add(1, 228, 105, 1, 1, 1, 5,  8, 1);
        add(1, 301, 100, 1, 1, 5, 0,  1, 1);
        add(1, 244, 115, 1, 1, 2, 15, 4, 1);
        add(1, 216, 100, 1, 1, 2, 15, 0, 0);
        add(1, 230, 116, 1, 1, 2, 15, 0, 0);
        add(1, 230, 105, 0, 1, 2, 15, 0, 0);
        add(1, 202, 140, 1, 1, 3, 0,  2, 1);
        add(1, 247, 141, 1, 1, 0, 1,  7, 1);
        add(1, 229, 155, 1, 1, 3, 15, 9, 1);
        add(2, 288, 100, 1, 1, 0, 0,  8, 0);
        add(2, 306, 103, 1, 1, 0, 3,  6, 1);
        add(2, 208, 140, 1, 1, 0, 0,  8, 0);
        add(2, 228, 140, 1, 1, 0, 0,  8, 0);
        add(2, 248, 140, 1, 1, 5, 0,  8, 1);
        add(3, 208, 100, 1, 1, 0, 0,  8, 1);
        add(3, 288, 100, 1, 1, 0, 0,  8, 1);
        add(3, 208, 140, 1, 1, 0, 0,  8, 1);
        add(4, 267, 100, 1, 1, 0, 0,  7, 0);
        add(4, 252, 100, 1, 1, 3, 0, 12, 1);
        add(4, 286, 102, 1, 1, 4, 2,  6, 1);
        add(4, 228, 140, 1, 1, 0, 0,  8, 1);
        add(6, 274, 100, 1, 1, 7, 0, 14, 1);
        add(6, 200, 100, 1, 1, 0, 0,  0, 1);
        add(6, 240, 140, 1, 1, 9, 0,  0, 1);
        add(7, 212, 100, 1, 1, 0, 0, 12, 1);
        add(7, 270, 100, 1, 1, 0, 0, 10, 1);

        repeat (3) @(negedge clk);
        chk("rst_pix_on", 24'(pix_on), 24'd0);
        chk("rst_de_out", 24'(de_out), 24'd0);
        chk("rst_hs_out", 24'(hs_out), 24'd0);
        chk("rst_vs_out", 24'(vs_out), 24'd0);
        chk("rst_glyph_num", 24'(glyph_num), 24'd0);
        chk("rst_glyph_addr", 24'(glyph_addr), 24'd0);
        chk("rst_ready", 24'(upd_ready), 24'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 24'(upd_ready), 24'd1);
        chk("vs_out_follows", 24'(vs_out), 24'd0);
        @(negedge clk);
        chk("vs_out_delayed", 24'(vs_out), 24'd1);

        run_phase(0);

        accept(24'h012345, 12'h330, 1'b1);
        @(negedge clk);
        fre_bcd = 24'h999999; upd_valid = 1'b1;
        chk("ready_blocked", 24'(upd_ready), 24'd0);
        @(negedge clk);
        upd_valid = 1'b0;
        run_phase(0);
        frame_edge(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        run_phase(1);

        accept(24'h000000, 12'h005, 1'b1);
        frame_edge(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        run_phase(2);

        accept(24'h000000, 12'h005, 1'b0);
        frame_edge(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        run_phase(3);

        accept(24'h123C45, 12'h100, 1'b1);
        frame_edge(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        run_phase(4);

        // Accept coinciding with the frame edge stays pending for one frame.
        frame_edge(1'b1, 24'h000777, 12'h999, 1'b0, 1'b1, 1'b0);
        run_phase(4);
        frame_edge(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        run_phase(6);

        @(negedge clk);
        hs_in = 1'b1;
        @(negedge clk);
        hs_in = 1'b0;
        chk("hs_delay_1", 24'(hs_out), 24'd0);
        @(negedge clk);
        chk("hs_delay_2", 24'(hs_out), 24'd1);
        @(negedge clk);
        chk("hs_delay_3", 24'(hs_out), 24'd0);

        accept(24'h555555, 12'h555, 1'b0);
        @(negedge clk);
        pix_x = 10'd274; pix_y = 10'd100; de_in = 1'b1; hs_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_pix_on", 24'(pix_on), 24'd0);
        chk("midrst_de_out", 24'(de_out), 24'd0);
        chk("midrst_hs_out", 24'(hs_out), 24'd0);
        chk("midrst_vs_out", 24'(vs_out), 24'd0);
        chk("midrst_ready", 24'(upd_ready), 24'd0);
        rst_n = 1'b1; de_in = 1'b0; hs_in = 1'b0;
        @(negedge clk);
        chk("midrst_ready_release", 24'(upd_ready), 24'd1);
        run_phase(7);
        frame_edge(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        run_phase(7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
